fpu_operand_sequencer: RTL and testbench
========================================

Name: fpu_operand_sequencer

Overview:
- Sits directly upstream of the free-running fpu and captures its results.
- Accepts operand pairs over a valid/ready interface into a small FIFO and presents one pair at a time on the fpu's op_A_in/op_B_in.
- Holds each pair stable long enough for the fpu to produce a result that reflects it, then captures data_out/status_out and offers the result downstream over valid/ready.
- Keeps a sticky status summary and a result counter.

Parameters:
- DEPTH, 4: operand FIFO entries; power of 2, >= 2.
- HOLD_CYCLES, 64: cycles operands are held before result capture; must be >= 64, which is two worst-case fpu passes.

Ports:
- clock100KHz  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO can accept; equals (fifo count != DEPTH).
- in_op_A  in  32  operand A: {sign, exp[5:0], mant[24:0]}.
- in_op_B  in  32  operand B, same format.
- op_A_out  out  32  to fpu op_A_in.
- op_B_out  out  32  to fpu op_B_in.
- fpu_data_in  in  32  from fpu data_out.
- fpu_status_in  in  4  from fpu status_out: 1000 underflow, 0100 overflow, 0010 inexact, 0001 exact.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  32  captured fpu result.
- res_status  out  4  captured fpu status.
- clear_sticky  in  1  single-cycle pulse; clears sticky_status.
- sticky_status  out  4  OR of all captured res_status since the last clear.
- done_count  out  8  number of results captured, wraps 255->0.

Behaviour:
- Reset (reset=0, asynchronous): FIFO empty, state IDLE, op_A_out=op_B_out=0, res_valid=0, res_data=0, res_status=0, sticky_status=0, done_count=0, internal hold counter=0.
  - in_ready=1 immediately after reset (FIFO empty).
  - Reset mid-operation discards FIFO contents and any in-flight or unaccepted result.
- FIFO:
  - Push when in_valid && in_ready; stores {in_op_A, in_op_B}.
  - Pop only from IDLE.
  - Full: in_ready=0 even if a pop occurs that cycle; no bypass.
  - A push and a pop in the same cycle when not full keep the count unchanged.
  - Pointers wrap modulo DEPTH.
  - Data pushed at edge N is poppable at the earliest in the cycle after edge N.
- State machine (IDLE, DRIVE, PRESENT):
  - IDLE: if FIFO non-empty, pop head; op_A_out/op_B_out <= head; hold counter <= HOLD_CYCLES-1; go DRIVE. Otherwise stay in IDLE; op outputs keep their last value.
  - DRIVE: op outputs stable. If counter != 0, decrement it. If counter == 0, then on the same edge:
    - res_data <= fpu_data_in, res_status <= fpu_status_in, res_valid <= 1;
    - done_count <= done_count+1;
    - sticky_status updated (see Sticky rules);
    - go PRESENT.
  - PRESENT: res_data/res_status stable while res_valid=1. When res_ready=1, res_valid <= 0 and go IDLE. The next pop happens no earlier than the following cycle.
- Latency: operands change at edge E → res_valid rises at edge E+HOLD_CYCLES. Push into an empty FIFO while in IDLE at edge P → op outputs update at edge P+1 → res_valid at edge P+1+HOLD_CYCLES.
- Throughput: one result per HOLD_CYCLES+2 cycles when res_ready is held high.
- Sticky rules:
  - On capture, sticky_status <= sticky_status | fpu_status_in.
  - clear_sticky alone: sticky_status <= 0.
  - clear_sticky coinciding with a capture: sticky_status <= fpu_status_in, i.e. the clear applies first and the new status is kept.
- res_ready is ignored while res_valid=0. in_valid is ignored while in_ready=0. Operands offered while in_ready=0 are not stored, and the upstream source must hold them.
- No arithmetic on data: operands and results pass unmodified.

Test Plan:
- Single add, connected to the real fpu: push A=0x3E000000, B=0x3E000000 (1.0+1.0) → op_A_out/op_B_out=0x3E000000 one edge after push; res_valid after 64 more edges; res_data=0x40000000, res_status=0001, done_count=1.
- Backpressure and full: push 5 pairs back-to-back with res_ready=0 → in_ready=0 while the FIFO holds 4 entries; the 5th pair is accepted only after the first pop. res_valid remains 1 with stable data until res_ready=1. Results then arrive in push order.
- Sticky and clear: capture a result with status 0010, then one with 0001 → sticky_status=0011. Pulse clear_sticky on the same edge as a capture with status 0100 → sticky_status=0100.
- Reset mid-DRIVE: assert reset=0 with 2 entries queued, 30 cycles into DRIVE → all outputs 0, in_ready=1 during reset; no res_valid after release until a new push.
- Counter wrap: capture 256 results → done_count returns to 0.
- Cancellation: push A=0x3E000000, B=0xBE000000 (1.0-1.0) → res_data=0x00000000, res_status=0001, captured exactly HOLD_CYCLES edges after the operands change.

Source files
------------

// File: rtl/fpu_operand_sequencer.sv
// Operand sequencer for a free-running fpu: queues operand pairs, holds each pair
// on the fpu inputs for a fixed settle time, then captures and offers the result.
module fpu_operand_sequencer #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 64
) (
  input  logic        clock100KHz,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_op_A,
  input  logic [31:0] in_op_B,
  output logic [31:0] op_A_out,
  output logic [31:0] op_B_out,
  input  logic [31:0] fpu_data_in,
  input  logic [3:0]  fpu_status_in,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [3:0]  res_status,
  input  logic        clear_sticky,
  output logic [3:0]  sticky_status,
  output logic [7:0]  done_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(HOLD_CYCLES);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_DRIVE   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_ONE   = CW'(1);

  logic [63:0]   mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic [1:0]    state_r;
  logic [CW-1:0] hold_cnt_r;
  logic          push_s;
  logic          pop_s;
  logic          capture_s;

  // Full blocks a push even when a pop happens on the same edge (no bypass).
  assign in_ready = (count_r != FULL_COUNT);

  // Handshake and state-derived strobes.
  always_comb begin
    push_s    = in_valid && in_ready;
    pop_s     = (state_r == ST_IDLE) && (count_r != {(AW + 1){1'b0}});
    capture_s = (state_r == ST_DRIVE) && (hold_cnt_r == {CW{1'b0}});
  end

  // Operand FIFO storage, pointers and occupancy.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 64'h0;
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {in_op_A, in_op_B};
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sequencing FSM: load operands, wait out the hold time, capture, present.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      hold_cnt_r <= {CW{1'b0}};
      op_A_out   <= 32'h0;
      op_B_out   <= 32'h0;
      res_valid  <= 1'b0;
      res_data   <= 32'h0;
      res_status <= 4'h0;
      done_count <= 8'h0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pop_s) begin
            {op_A_out, op_B_out} <= mem_r[rd_ptr_r];
            hold_cnt_r           <= HOLD_LOAD;
            state_r              <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (capture_s) begin
            res_data   <= fpu_data_in;
            res_status <= fpu_status_in;
            res_valid  <= 1'b1;
            done_count <= done_count + 8'd1;
            state_r    <= ST_PRESENT;
          end else begin
            hold_cnt_r <= hold_cnt_r - HOLD_ONE;
          end
        end
        ST_PRESENT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_r   <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // A clear on the capture edge wipes history first, so only the new status survives.
  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      sticky_status <= 4'h0;
    end else if (capture_s) begin
      sticky_status <= (clear_sticky ? 4'h0 : sticky_status) | fpu_status_in;
    end else if (clear_sticky) begin
      sticky_status <= 4'h0;
    end else begin
      sticky_status <= sticky_status;
    end
  end

endmodule

// File: tb/tb_fpu_operand_sequencer.sv
// Directed bench for fpu_operand_sequencer with a tiny combinational fpu stand-in.
`timescale 1ns/1ps
module tb_fpu_operand_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_op_A;
  logic [31:0] in_op_B;
  logic [31:0] op_A_out;
  logic [31:0] op_B_out;
  logic [31:0] fpu_data;
  logic [3:0]  fpu_status;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_status;
  logic        clear_sticky;
  logic [3:0]  sticky_status;
  logic [7:0]  done_count;

  int n_cmp = 0;
  int n_err = 0;

  fpu_operand_sequencer #(.DEPTH(4), .HOLD_CYCLES(64)) dut (
    .clock100KHz  (clk),
    .reset        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_op_A      (in_op_A),
    .in_op_B      (in_op_B),
    .op_A_out     (op_A_out),
    .op_B_out     (op_B_out),
    .fpu_data_in  (fpu_data),
    .fpu_status_in(fpu_status),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_status   (res_status),
    .clear_sticky (clear_sticky),
    .sticky_status(sticky_status),
    .done_count   (done_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // fpu stand-in: two known float cases, otherwise data=A^B and status=B[3:0].
  always_comb begin
    if (op_A_out == 32'h3E000000 && op_B_out == 32'h3E000000) begin
      fpu_data   = 32'h40000000;
      fpu_status = 4'b0001;
    end else if (op_A_out == 32'h3E000000 && op_B_out == 32'hBE000000) begin
      fpu_data   = 32'h00000000;
      fpu_status = 4'b0001;
    end else begin
      fpu_data   = op_A_out ^ op_B_out;
      fpu_status = op_B_out[3:0];
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op_A  = a;
    in_op_B  = b;
    while (!in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("push_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string tag);
    int n = 0;
    while (!res_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_val(tag, {31'b0, res_valid}, 32'h1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  logic [31:0] bp_a  [6] = '{32'hA0000100, 32'hA0000200, 32'hA0000300,
                             32'hA0000400, 32'hA0000500, 32'hA0000600};
  logic [31:0] bp_b  [6] = '{32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6};
  logic [31:0] bp_d  [6] = '{32'hA0000101, 32'hA0000202, 32'hA0000303,
                             32'hA0000404, 32'hA0000505, 32'hA0000606};
  logic [3:0]  bp_s  [6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6};

  initial begin
    int n;
    logic seen;
    rst_n        = 1'b0;
    in_valid     = 1'b0;
    in_op_A      = 32'h0;
    in_op_B      = 32'h0;
    res_ready    = 1'b0;
    clear_sticky = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check_val("rst_res_valid", {31'b0, res_valid}, 32'h0);
    check_val("rst_op_a", op_A_out, 32'h0);
    check_val("rst_done", {24'b0, done_count}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single add 1.0 + 1.0
    push(32'h3E000000, 32'h3E000000);
    check_val("add_op_a_before_pop", op_A_out, 32'h0);
    @(negedge clk);
    check_val("add_op_a", op_A_out, 32'h3E000000);
    check_val("add_op_b", op_B_out, 32'h3E000000);
    repeat (63) @(negedge clk);
    check_val("add_not_early", {31'b0, res_valid}, 32'h0);
    @(negedge clk);
    check_val("add_valid", {31'b0, res_valid}, 32'h1);
    check_val("add_data", res_data, 32'h40000000);
    check_val("add_status", {28'b0, res_status}, 32'h1);
    check_val("add_done", {24'b0, done_count}, 32'h1);
    repeat (4) @(negedge clk);
    check_val("add_held", {31'b0, res_valid}, 32'h1);
    accept();
    check_val("add_accepted", {31'b0, res_valid}, 32'h0);

    // Cancellation 1.0 - 1.0, latency counted from the operand change
    push(32'h3E000000, 32'hBE000000);
    @(negedge clk);
    check_val("cancel_op_b", op_B_out, 32'hBE000000);
    n = 0;
    while (!res_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("cancel_latency", n, 32'd64);
    check_val("cancel_data", res_data, 32'h0);
    check_val("cancel_status", {28'b0, res_status}, 32'h1);
    accept();

    // Sticky accumulation and clear coinciding with capture
    check_val("sticky_pre", {28'b0, sticky_status}, 32'h1);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    check_val("sticky_cleared", {28'b0, sticky_status}, 32'h0);
    push(32'h11110000, 32'h00000002);
    wait_result("sticky_r1_valid");
    check_val("sticky_r1_data", res_data, 32'h11110002);
    accept();
    push(32'h22220000, 32'h00000001);
    wait_result("sticky_r2_valid");
    accept();
    check_val("sticky_or", {28'b0, sticky_status}, 32'h3);
    push(32'h33330000, 32'h00000004);
    repeat (64) @(negedge clk);
    check_val("sticky_pre_capture", {31'b0, res_valid}, 32'h0);
    clear_sticky = 1'b1;
    @(negedge clk);
    clear_sticky = 1'b0;
    check_val("sticky_clr_cap_valid", {31'b0, res_valid}, 32'h1);
    check_val("sticky_clr_cap", {28'b0, sticky_status}, 32'h4);
    accept();
    check_val("done_five", {24'b0, done_count}, 32'h5);

    // Backpressure: FIFO fills while the first pair is in flight
    for (int k = 0; k < 5; k++) push(bp_a[k], bp_b[k]);
    check_val("bp_full", {31'b0, in_ready}, 32'h0);
    fork
      push(bp_a[5], bp_b[5]);
      begin
        for (int k = 0; k < 6; k++) begin
          wait_result($sformatf("bp_valid_%0d", k));
          check_val($sformatf("bp_data_%0d", k), res_data, bp_d[k]);
          check_val($sformatf("bp_status_%0d", k), {28'b0, res_status}, {28'b0, bp_s[k]});
          if (k == 0) begin
            repeat (3) @(negedge clk);
            check_val("bp_hold_valid", {31'b0, res_valid}, 32'h1);
            check_val("bp_hold_data", res_data, bp_d[0]);
            check_val("bp_still_full", {31'b0, in_ready}, 32'h0);
          end
          accept();
        end
      end
    join
    check_val("bp_done", {24'b0, done_count}, 32'd11);

    // Reset 30 cycles into DRIVE with two entries queued
    for (int k = 0; k < 3; k++) push(bp_a[k], bp_b[k]);
    repeat (28) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_op_a", op_A_out, 32'h0);
    check_val("mid_rst_op_b", op_B_out, 32'h0);
    check_val("mid_rst_res_data", res_data, 32'h0);
    check_val("mid_rst_res_status", {28'b0, res_status}, 32'h0);
    check_val("mid_rst_sticky", {28'b0, sticky_status}, 32'h0);
    check_val("mid_rst_done", {24'b0, done_count}, 32'h0);
    check_val("mid_rst_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check_val("rst_no_stale_result", {31'b0, seen}, 32'h0);
    push(32'h44440000, 32'h00000008);
    wait_result("post_rst_valid");
    check_val("post_rst_data", res_data, 32'h44440008);
    check_val("post_rst_sticky", {28'b0, sticky_status}, 32'h8);
    check_val("post_rst_done", {24'b0, done_count}, 32'h1);
    accept();

    // Counter wrap at 256 captures
    for (int k = 0; k < 254; k++) begin
      push(32'h00001000 + 32'(k), 32'h00000001);
      wait_result("wrap_valid");
      accept();
    end
    check_val("wrap_255", {24'b0, done_count}, 32'd255);
    push(32'h00005000, 32'h00000001);
    wait_result("wrap_last_valid");
    check_val("wrap_zero", {24'b0, done_count}, 32'h0);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
